// File: rtl/audio_mix_pwm.sv
// N-channel audio mixer: per-channel volume and mute, sequential accumulation
// once per PWM frame, saturating output with sticky clip flag, PWM DAC output.
module audio_mix_pwm #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int VOL_W    = 4
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       enable_in,
    input  logic [NUM_CH*SAMPLE_W-1:0] audio_in,
    input  logic [NUM_CH*VOL_W-1:0]    volume_in,
    input  logic [NUM_CH-1:0]          mute_in,
    input  logic                       clip_clear_in,
    output logic [SAMPLE_W-1:0]        mix_out,
    output logic                       mix_valid_out,
    output logic                       clip_out,
    output logic                       pwm_out
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = SAMPLE_W + VOL_W;
    localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(NUM_CH) + 1;
    localparam logic [ACC_W-1:0] FULL_SCALE = ACC_W'({SAMPLE_W{1'b1}});
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

    // A mix needs NUM_CH+1 cycles after the snapshot and must land before the next frame start.
    if (NUM_CH < 1 || NUM_CH + 2 > 2 ** SAMPLE_W) begin : g_param_check
        $error("audio_mix_pwm: NUM_CH must satisfy 1 <= NUM_CH <= 2**SAMPLE_W - 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SAT
    } state_t;

    state_t              state, state_next;
    logic [CH_W-1:0]     ch, ch_next;
    logic [ACC_W-1:0]    acc, acc_next;
    logic [SAMPLE_W-1:0] pwm_cnt, duty, duty_next;
    logic [SAMPLE_W-1:0] sample_q [NUM_CH];
    logic [VOL_W-1:0]    vol_q    [NUM_CH];
    logic [NUM_CH-1:0]   mute_q;
    logic [PROD_W-1:0]   prod, term;
    logic                frame_start, sat_fire, clipping;

    assign frame_start = enable_in && (pwm_cnt == '0);
    assign sat_fire    = enable_in && (state == SAT);
    assign clipping    = acc > FULL_SCALE;
    assign duty_next   = frame_start ? mix_out : duty;

    // NOTE: the snapshot registers have no reset; the FSM only reads them after a frame start has loaded them.
    always_ff @(posedge clk_in) begin
        if (frame_start && !reset_in) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sample_q[k] <= audio_in[k*SAMPLE_W +: SAMPLE_W];
                vol_q[k]    <= volume_in[k*VOL_W +: VOL_W];
            end
            mute_q <= mute_in;
        end
    end

    // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        acc_next   = acc;
        prod       = PROD_W'(sample_q[ch]) * PROD_W'(vol_q[ch]);
        term       = mute_q[ch] ? '0 : (prod >> (VOL_W - 1));

        if (frame_start) begin
            state_next = ACCUM;
            ch_next    = '0;
            acc_next   = '0;
        end else if (enable_in) begin
            case (state)
                IDLE: state_next = IDLE;
                ACCUM: begin
                    acc_next = acc + ACC_W'(term);
                    if (ch == LAST_CH) begin
                        state_next = SAT;
                    end else begin
                        ch_next = ch + 1'b1;
                    end
                end
                SAT:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            ch            <= '0;
            acc           <= '0;
            pwm_cnt       <= '0;
            duty          <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            clip_out      <= 1'b0;
            pwm_out       <= 1'b0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
            acc   <= acc_next;
            duty  <= duty_next;
            if (enable_in) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            // Compare against the duty taking effect this edge so the first period cycle is not stale.
            pwm_out       <= enable_in && (pwm_cnt < duty_next);
            mix_valid_out <= sat_fire;
            if (sat_fire) begin
                mix_out <= clipping ? '1 : acc[SAMPLE_W-1:0];
            end
            if (sat_fire && clipping) begin
                clip_out <= 1'b1;
            end else if (clip_clear_in) begin
                clip_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_mix_pwm.sv
// Self-checking bench for audio_mix_pwm: directed scenarios plus randomized
// frames compared against a frame-level arithmetic model.
module tb_audio_mix_pwm;

    localparam int NUM_CH = 2;
    localparam int SW     = 8;
    localparam int VW     = 4;
    localparam int FRAME  = 1 << SW;
    localparam int MAXV   = FRAME - 1;

    logic                   clk_in = 1'b0;
    logic                   reset_in;
    logic                   enable_in;
    logic [NUM_CH*SW-1:0]   audio_in;
    logic [NUM_CH*VW-1:0]   volume_in;
    logic [NUM_CH-1:0]      mute_in;
    logic                   clip_clear_in;
    logic [SW-1:0]          mix_out;
    logic                   mix_valid_out;
    logic                   clip_out;
    logic                   pwm_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference: counter phase, duty, last mix, pending mix countdown.
    int   m_cnt = 0, m_duty = 0, m_mix = 0, m_target = 0, m_left = 0;
    logic m_pwm = 1'b0, m_clip = 1'b0;

    audio_mix_pwm #(.NUM_CH(NUM_CH), .SAMPLE_W(SW), .VOL_W(VW)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .enable_in     (enable_in),
        .audio_in      (audio_in),
        .volume_in     (volume_in),
        .mute_in       (mute_in),
        .clip_clear_in (clip_clear_in),
        .mix_out       (mix_out),
        .mix_valid_out (mix_valid_out),
        .clip_out      (clip_out),
        .pwm_out       (pwm_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mix_of(logic [NUM_CH*SW-1:0] a, logic [NUM_CH*VW-1:0] v,
                                  logic [NUM_CH-1:0] m);
        int s = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!m[k]) s += (int'(a[k*SW +: SW]) * int'(v[k*VW +: VW])) / (1 << (VW - 1));
        end
        return s;
    endfunction

    function automatic int sat(int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    task automatic set_ch(int k, int s, int v, bit mu);
        audio_in[k*SW +: SW]  = SW'(s);
        volume_in[k*VW +: VW] = VW'(v);
        mute_in[k]            = mu;
    endtask

    // One clock; inputs are sampled before the edge, the model advances, outputs settle #1 later.
    task automatic tick();
        logic rst, en, clr, fs, fire;
        int   target;
        rst    = reset_in;
        en     = enable_in;
        clr    = clip_clear_in;
        fs     = en && (m_cnt == 0);
        target = mix_of(audio_in, volume_in, mute_in);
        @(posedge clk_in);
        #1;
        fire = 1'b0;
        if (rst) begin
            m_cnt = 0; m_duty = 0; m_mix = 0; m_left = 0; m_pwm = 1'b0; m_clip = 1'b0;
        end else if (!en) begin
            m_pwm = 1'b0;
            if (clr) m_clip = 1'b0;
        end else begin
            m_pwm = (m_cnt < (fs ? m_mix : m_duty));
            if (fs) begin
                m_duty   = m_mix;
                m_target = target;
                m_left   = NUM_CH + 1;
            end else if (m_left > 0) begin
                m_left--;
                fire = (m_left == 0);
            end
            if (fire) m_mix = sat(m_target);
            if (fire && m_target > MAXV) m_clip = 1'b1;
            else if (clr) m_clip = 1'b0;
            m_cnt = (m_cnt + 1) % FRAME;
        end
    endtask

    task automatic run_to_frame_start();
        int n = 0;
        while (m_cnt != 0 && n < FRAME + 2) begin
            tick();
            n++;
        end
        n_checks++;
        if (m_cnt != 0) begin
            n_fail++;
            $display("FAIL frame_align: phase %0d, required 0", m_cnt);
        end
    endtask

    // Snapshot at the next frame start, then wait (bounded) for the resulting mix_valid_out.
    task automatic mix_frame(output int lat);
        run_to_frame_start();
        tick();
        lat = 0;
        for (int i = 1; i <= 2 * NUM_CH + 8; i++) begin
            tick();
            if (mix_valid_out === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat == 0) begin
            n_fail++;
            $display("FAIL mix_timeout: no mix_valid_out within %0d cycles", 2 * NUM_CH + 8);
        end
    endtask

    // Runs one full PWM period from a frame start and measures it.
    task automatic count_frame(output int hi, output int err, output int nval,
                               output int got_mix, output logic last_pwm);
        run_to_frame_start();
        hi = 0; err = 0; nval = 0; got_mix = -1; last_pwm = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (pwm_out === 1'b1) hi++;
            if (pwm_out !== m_pwm) err++;
            if (mix_valid_out === 1'b1) begin
                nval++;
                got_mix = int'(mix_out);
            end
            last_pwm = pwm_out;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        enable_in = 1'b1;
        tick();
        tick();
        reset_in = 1'b0;
        n_checks++; if (mix_out !== 8'h00) begin n_fail++; $display("FAIL reset_mix: got %0h, required 0", mix_out); end
        n_checks++; if (mix_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", mix_valid_out); end
        n_checks++; if (clip_out !== 1'b0) begin n_fail++; $display("FAIL reset_clip: got %b, required 0", clip_out); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b, required 0", pwm_out); end
    endtask

    task automatic test_unity_sum();
        int lat, hi, err, nval, gm;
        logic lp;
        set_ch(0, 8'h40, 8, 1'b0);
        set_ch(1, 8'h20, 8, 1'b0);
        mix_frame(lat);
        n_checks++; if (lat != NUM_CH + 1) begin n_fail++; $display("FAIL unity_latency: got %0d, required %0d", lat, NUM_CH + 1); end
        n_checks++; if (mix_out !== 8'h60) begin n_fail++; $display("FAIL unity_mix: got %0h, required 60", mix_out); end
        tick();
        n_checks++; if (mix_valid_out !== 1'b0) begin n_fail++; $display("FAIL unity_pulse_width: valid still %b", mix_valid_out); end
        count_frame(hi, err, nval, gm, lp);
        n_checks++; if (hi != 96) begin n_fail++; $display("FAIL unity_pwm_high: got %0d, required 96", hi); end
        n_checks++; if (err != 0) begin n_fail++; $display("FAIL unity_pwm_trace: %0d cycles differ, required 0", err); end
        n_checks++; if (clip_out !== 1'b0) begin n_fail++; $display("FAIL unity_clip: got %b, required 0", clip_out); end
    endtask

    task automatic test_saturation();
        int lat;
        set_ch(0, 8'hC0, 8, 1'b0);
        set_ch(1, 8'h80, 8, 1'b0);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'hFF) begin n_fail++; $display("FAIL sat_mix: got %0h, required ff", mix_out); end
        n_checks++; if (clip_out !== 1'b1) begin n_fail++; $display("FAIL sat_clip: got %b, required 1", clip_out); end
        set_ch(0, 8'h10, 8, 1'b0);
        set_ch(1, 8'h10, 8, 1'b0);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'h20) begin n_fail++; $display("FAIL sat_after_mix: got %0h, required 20", mix_out); end
        n_checks++; if (clip_out !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b, required 1", clip_out); end
        clip_clear_in = 1'b1;
        tick();
        clip_clear_in = 1'b0;
        n_checks++; if (clip_out !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b, required 0", clip_out); end
        // Clear lands on the same edge as a saturating SAT: set must win.
        set_ch(0, 8'hC0, 8, 1'b0);
        set_ch(1, 8'h80, 8, 1'b0);
        run_to_frame_start();
        tick();
        for (int i = 0; i < NUM_CH; i++) tick();
        clip_clear_in = 1'b1;
        tick();
        clip_clear_in = 1'b0;
        n_checks++; if (mix_valid_out !== 1'b1) begin n_fail++; $display("FAIL sat_coincide_valid: got %b, required 1", mix_valid_out); end
        n_checks++; if (clip_out !== 1'b1) begin n_fail++; $display("FAIL sat_coincide_clip: got %b, required 1", clip_out); end
    endtask

    task automatic test_volume_mute();
        int lat;
        clip_clear_in = 1'b1;
        tick();
        clip_clear_in = 1'b0;
        set_ch(0, 8'h80, 4, 1'b0);
        set_ch(1, 8'h77, 8, 1'b1);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'h40) begin n_fail++; $display("FAIL vol_half: got %0h, required 40", mix_out); end
        set_ch(0, 8'h80, 15, 1'b0);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'hF0) begin n_fail++; $display("FAIL vol_max: got %0h, required f0", mix_out); end
        set_ch(0, 8'h80, 0, 1'b0);
        set_ch(1, 8'h77, 0, 1'b0);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'h00) begin n_fail++; $display("FAIL vol_zero: got %0h, required 0", mix_out); end
        set_ch(0, 8'hFF, 15, 1'b1);
        set_ch(1, 8'hFF, 15, 1'b1);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'h00) begin n_fail++; $display("FAIL all_muted: got %0h, required 0", mix_out); end
        n_checks++; if (clip_out !== 1'b0) begin n_fail++; $display("FAIL vol_clip: got %b, required 0", clip_out); end
    endtask

    task automatic test_duty_bounds();
        int lat, hi, err, nval, gm, bad;
        logic lp;
        count_frame(hi, err, nval, gm, lp);
        n_checks++; if (hi != 0) begin n_fail++; $display("FAIL duty_zero: %0d high cycles, required 0", hi); end
        set_ch(0, 8'hFF, 8, 1'b0);
        set_ch(1, 8'hFF, 8, 1'b0);
        mix_frame(lat);
        count_frame(hi, err, nval, gm, lp);
        n_checks++; if (hi != MAXV) begin n_fail++; $display("FAIL duty_full: %0d high cycles, required %0d", hi, MAXV); end
        n_checks++; if (lp !== 1'b0) begin n_fail++; $display("FAIL duty_full_low_slot: last cycle %b, required 0", lp); end
        // Mid-frame input change must not disturb the running frame.
        set_ch(0, 8'h30, 8, 1'b0);
        set_ch(1, 8'h00, 8, 1'b0);
        mix_frame(lat);
        n_checks++; if (mix_out !== 8'h30) begin n_fail++; $display("FAIL midframe_first: got %0h, required 30", mix_out); end
        set_ch(0, 8'h90, 8, 1'b0);
        set_ch(1, 8'h10, 8, 1'b0);
        bad = 0;
        while (m_cnt != 0 && bad < FRAME) begin
            tick();
            if (mix_valid_out !== 1'b0 || mix_out !== 8'h30) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midframe_hold: %0d disturbed cycles, required 0", bad); end
        count_frame(hi, err, nval, gm, lp);
        n_checks++; if (hi != 8'h30) begin n_fail++; $display("FAIL midframe_duty: %0d high cycles, required 48", hi); end
        n_checks++; if (gm != 8'hA0) begin n_fail++; $display("FAIL midframe_next_mix: got %0h, required a0", gm); end
    endtask

    task automatic test_enable_pause();
        int bad_pwm, bad_val, lat, err;
        set_ch(0, 8'h50, 8, 1'b0);
        set_ch(1, 8'h25, 8, 1'b0);
        run_to_frame_start();
        tick();
        tick();
        enable_in = 1'b0;
        bad_pwm = 0;
        bad_val = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pwm_out !== 1'b0) bad_pwm++;
            if (mix_valid_out !== 1'b0) bad_val++;
        end
        enable_in = 1'b1;
        n_checks++; if (bad_pwm != 0) begin n_fail++; $display("FAIL pause_pwm: %0d high cycles, required 0", bad_pwm); end
        n_checks++; if (bad_val != 0) begin n_fail++; $display("FAIL pause_valid: %0d pulses, required 0", bad_val); end
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mix_valid_out === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++; if (lat != NUM_CH) begin n_fail++; $display("FAIL pause_resume_latency: got %0d, required %0d", lat, NUM_CH); end
        n_checks++; if (mix_out !== 8'h75) begin n_fail++; $display("FAIL pause_mix: got %0h, required 75", mix_out); end
        err = 0;
        for (int i = 0; i < FRAME + 40; i++) begin
            tick();
            if (pwm_out !== m_pwm) err++;
        end
        n_checks++; if (err != 0) begin n_fail++; $display("FAIL pause_phase: %0d pwm cycles differ, required 0", err); end
    endtask

    task automatic test_reset_mid_accum();
        int lat, bad;
        set_ch(0, 8'hC0, 8, 1'b0);
        set_ch(1, 8'h80, 8, 1'b0);
        mix_frame(lat);
        set_ch(0, 8'h11, 8, 1'b0);
        set_ch(1, 8'h22, 8, 1'b0);
        run_to_frame_start();
        tick();
        tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        enable_in = 1'b0;
        n_checks++; if (mix_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_mix: got %0h, required 0", mix_out); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pwm: got %b, required 0", pwm_out); end
        n_checks++; if (clip_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clip: got %b, required 0", clip_out); end
        bad = (mix_valid_out !== 1'b0) ? 1 : 0;
        for (int i = 0; i < NUM_CH + 3; i++) begin
            tick();
            if (mix_valid_out !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: %0d pulses, required 0", bad); end
        enable_in = 1'b1;
        mix_frame(lat);
        n_checks++; if (lat != NUM_CH + 1) begin n_fail++; $display("FAIL rst_post_latency: got %0d, required %0d", lat, NUM_CH + 1); end
        n_checks++; if (mix_out !== 8'h33) begin n_fail++; $display("FAIL rst_post_mix: got %0h, required 33", mix_out); end
    endtask

    task automatic test_random_frames();
        int hi, err, nval, gm, exp_mix;
        logic lp;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                set_ch(k, int'($urandom_range(0, MAXV)), int'($urandom_range(0, (1 << VW) - 1)),
                       ($urandom_range(0, 3) == 0));
            end
            exp_mix = sat(mix_of(audio_in, volume_in, mute_in));
            count_frame(hi, err, nval, gm, lp);
            n_checks++; if (nval != 1) begin n_fail++; $display("FAIL rand_valid_count f%0d: got %0d, required 1", f, nval); end
            n_checks++; if (gm != exp_mix) begin n_fail++; $display("FAIL rand_mix f%0d: got %0h, required %0h", f, gm, exp_mix); end
            n_checks++; if (clip_out !== m_clip) begin n_fail++; $display("FAIL rand_clip f%0d: got %b, required %b", f, clip_out, m_clip); end
            n_checks++; if (err != 0) begin n_fail++; $display("FAIL rand_pwm f%0d: %0d cycles differ, required 0", f, err); end
        end
    endtask

    initial begin
        reset_in      = 1'b1;
        enable_in     = 1'b0;
        audio_in      = '0;
        volume_in     = '0;
        mute_in       = '0;
        clip_clear_in = 1'b0;
        test_reset();
        test_unity_sum();
        test_saturation();
        test_volume_mute();
        test_duty_bounds();
        test_enable_pause();
        test_reset_mid_accum();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_mix_pwm.md
Name: audio_mix_pwm

Overview:
N-channel parametrised audio mixer with integrated PWM DAC. It generalises the fixed two-source (BGM + SFX) sum-and-clamp path into NUM_CH unsigned channels, each with per-channel volume and mute. Channels are accumulated sequentially, one per cycle, once per PWM frame. The result is saturated, reported with a sticky clip flag, and driven as a glitch-free PWM bit. It sits between the SD/audio sources and the aud_pwm pad logic.

Parameters:
NUM_CH, 2, number of input channels (>=1)
SAMPLE_W, 8, bits per unsigned input sample; also output/PWM resolution
VOL_W, 4, bits per volume field; gain = vol / 2^(VOL_W-1), so 8 = unity for VOL_W=4

Ports:
clk_in  input  1  system clock
reset_in  input  1  synchronous, active-high reset
enable_in  input  1  1 = run; 0 = freeze counter/FSM, force pwm_out low
audio_in  input  NUM_CH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W], unsigned
volume_in  input  NUM_CH*VOL_W  channel k volume at [k*VOL_W +: VOL_W]
mute_in  input  NUM_CH  1 = channel excluded from sum
clip_clear_in  input  1  clears clip_out
mix_out  output  SAMPLE_W  latest saturated mix
mix_valid_out  output  1  one-cycle pulse when mix_out updates
clip_out  output  1  sticky: a mix saturated since last clear
pwm_out  output  1  PWM bit, 1 = high phase

Behaviour:
- Reset (synchronous, active-high): pwm_cnt=0, duty=0, acc=0, FSM=IDLE, mix_out=0, mix_valid_out=0, clip_out=0, pwm_out=0.
- Reset mid-accumulation aborts the mix: no mix_valid_out pulse is produced.
- pwm_cnt: SAMPLE_W-bit counter. It increments each cycle while enable_in=1 and wraps 2^SAMPLE_W-1 -> 0.
- Frame start is the cycle in which pwm_cnt==0 and enable_in=1. In that cycle:
  - audio_in, volume_in and mute_in are snapshotted.
  - duty <= mix_out.
  - acc <= 0.
  - FSM -> ACCUM with ch=0.
- Inputs that change during a frame are ignored until the next snapshot.
- FSM states and transitions:
  - IDLE: wait for frame start.
  - ACCUM: one channel per cycle. acc += mute[ch] ? 0 : (sample[ch]*vol[ch]) >> (VOL_W-1). ch increments; after ch=NUM_CH-1, go to SAT.
  - SAT: mix_out <= (acc > 2^SAMPLE_W-1) ? 2^SAMPLE_W-1 : acc[SAMPLE_W-1:0]. mix_valid_out=1 in the following cycle only. If saturated, set clip_out. Go to IDLE.
- Latency: if the snapshot is at cycle T, mix_out and mix_valid_out change at T+NUM_CH+1. The new value reaches pwm_out at the next frame start, one full frame later.
- acc width: SAMPLE_W + VOL_W + clog2(NUM_CH) + 1 bits. No overflow for any input.
- Elaboration-time check: NUM_CH+2 <= 2^SAMPLE_W, so a mix always completes within one frame.
- pwm_out is registered and equals enable_in && (pwm_cnt < duty):
  - duty=0: pwm_out always 0.
  - duty=2^SAMPLE_W-1: high 2^SAMPLE_W-1 cycles, low 1 cycle.
  - duty changes only at frame start, so there are no mid-period glitches.
- enable_in=0: pwm_cnt, FSM, acc and duty hold; pwm_out=0; mix_valid_out=0. clip_clear_in still works. On re-enable, operation resumes exactly where it stopped.
- clip_out: set on a saturated SAT, cleared by clip_clear_in. If both occur in the same cycle, set wins.
- All volumes at 0 or all channels muted: mix_out=0, clip not set.

Test Plan:
(defaults NUM_CH=2, SAMPLE_W=8, VOL_W=4)
1. Unity sum: ch0=0x40, ch1=0x20, vol=8/8, unmuted -> mix_out=0x60 with mix_valid_out at T+3; next frame pwm_out high exactly 96 of 256 cycles; clip_out=0.
2. Saturation: ch0=0xC0, ch1=0x80, vol=8/8 -> mix_out=0xFF, clip_out=1 and stays 1 across later unsaturated frames. Pulse clip_clear_in -> 0. Clear coinciding with a saturating SAT -> clip_out=1.
3. Volume/mute:
   - ch0=0x80 vol=4, ch1 muted -> 0x40.
   - ch0=0x80 vol=15 -> 0xF0.
   - vol=0 on both -> 0x00.
4. Duty bounds:
   - mix 0x00 -> pwm_out constant 0 for a full frame.
   - mix 0xFF -> 255 high, 1 low per frame.
   - Change audio_in mid-frame -> duty and mix unaffected until the next frame start.
5. enable_in low for 50 cycles during ACCUM -> pwm_out=0, pwm_cnt frozen. On re-enable the mix completes with the correct value, 50 cycles late.
6. reset_in asserted during ACCUM -> next cycle mix_out=0, pwm_out=0, clip_out=0, no mix_valid_out pulse. The first post-reset frame produces a correct mix.
